// File: rtl/mux41_rr_arbiter_if.sv
// mux41_rr_arbiter_if
// Bundles the requester-side and grant-side signals of the 4:1 arbitrated mux.
//   i_req        4   request lines, bit n = requester n
//   i_d_0..i_d_3 DW  data words of requesters 0..3
//   o_gnt        4   one-hot grant
//   o_sel        2   encoded grant index / mux select
//   o_valid      1   grant active
//   o_y          DW  selected data word, 0 while no grant is active
// Modports: master = requester side, slave = arbiter side.
interface mux41_rr_arbiter_if #(
    parameter int DW = 4
);
    logic [3:0]    i_req;
    logic [DW-1:0] i_d_0;
    logic [DW-1:0] i_d_1;
    logic [DW-1:0] i_d_2;
    logic [DW-1:0] i_d_3;
    logic [3:0]    o_gnt;
    logic [1:0]    o_sel;
    logic          o_valid;
    logic [DW-1:0] o_y;

    modport master (
        output i_req, i_d_0, i_d_1, i_d_2, i_d_3,
        input  o_gnt, o_sel, o_valid, o_y
    );

    modport slave (
        input  i_req, i_d_0, i_d_1, i_d_2, i_d_3,
        output o_gnt, o_sel, o_valid, o_y
    );
endinterface

// File: rtl/mux41_rr_arbiter.sv
// mux41_rr_arbiter
// Shares a 4:1 DW-bit data mux between four requesters. One requester is
// granted at a time. A hold counter forces a hand-over after MAX_HOLD
// consecutive cycles when someone else is waiting.
//   i_clk  system clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    mux41_rr_arbiter_if.slave (requests, data, grant, select, valid, y)
// Parameters: DW data width, MAX_HOLD max consecutive grant cycles (1..15).
// Build option: define MUX41_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 highest); the default build is round-robin.
//
// state | meaning
// IDLE  | no grant active, o_valid = 0
// GRANT | requester o_sel owns the mux, o_valid = 1
module mux41_rr_arbiter #(
    parameter int DW       = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mux41_rr_arbiter_if.slave   bus
);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] others;
    logic [1:0] win;
    logic       load;
`ifndef MUX41_ARB_FIXED_PRIO_EN
    logic [1:0] last_gnt_q, last_gnt_d;
`endif

    // Pending requests excluding the current owner; equals i_req in IDLE
    // because gnt_q is zero there.
    assign others = bus.i_req & ~gnt_q;

`ifdef MUX41_ARB_FIXED_PRIO_EN
    always_comb begin
        win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (others[k]) win = 2'(k);
        end
    end
`else
    // Search last+1..last+4; iterating downward lets the nearest hit win.
    // In GRANT last_gnt equals the owner, so this also covers g+1 order.
    always_comb begin
        win = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (others[last_gnt_q + 2'(k)]) win = last_gnt_q + 2'(k);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        hold_cnt_d = hold_cnt_q;
        load       = 1'b0;
`ifndef MUX41_ARB_FIXED_PRIO_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.i_req) load = 1'b1;
            end
            GRANT: begin
                if (!bus.i_req[sel_q]) begin
                    if (|others) begin
                        load = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = 4'd0;
                        valid_d    = 1'b0;
                        hold_cnt_d = 4'd0;
                    end
                end else if (hold_cnt_q == HOLD_MAX && |others) begin
                    load = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d    = GRANT;
            gnt_d      = 4'b0001 << win;
            sel_d      = win;
            valid_d    = 1'b1;
            hold_cnt_d = 4'd1;
`ifndef MUX41_ARB_FIXED_PRIO_EN
            last_gnt_d = win;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'd0;
            sel_q      <= 2'd0;
            valid_q    <= 1'b0;
            hold_cnt_q <= 4'd0;
`ifndef MUX41_ARB_FIXED_PRIO_EN
            last_gnt_q <= 2'd3;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            hold_cnt_q <= hold_cnt_d;
`ifndef MUX41_ARB_FIXED_PRIO_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign bus.o_gnt   = gnt_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_valid = valid_q;

    always_comb begin
        bus.o_y = '0;
        if (valid_q) begin
            case (sel_q)
                2'd0:    bus.o_y = bus.i_d_0;
                2'd1:    bus.o_y = bus.i_d_1;
                2'd2:    bus.o_y = bus.i_d_2;
                default: bus.o_y = bus.i_d_3;
            endcase
        end
    end
endmodule

// File: tb/tb_mux41_rr_arbiter.sv
module tb_mux41_rr_arbiter;
    localparam int DW       = 4;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    mux41_rr_arbiter_if #(.DW(DW)) bus ();

    mux41_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner index (-1 = none), hold count, last owner.
    int m_own, m_hold, m_last;

    function automatic int pick(input int start, input logic [3:0] r);
`ifdef MUX41_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (r[(start + k) % 4]) return (start + k) % 4;
`endif
        return -1;
    endfunction

    function automatic int next_owner(input int own, input int hold, input int last,
                                      input logic [3:0] r);
        logic [3:0] oth;
        if (own < 0) return (r == 4'd0) ? -1 : pick(last, r);
        oth      = r;
        oth[own] = 1'b0;
        if (!r[own]) return (oth == 4'd0) ? -1 : pick(own, oth);
        if (hold >= MAX_HOLD && oth != 4'd0) return pick(own, oth);
        return own;
    endfunction

    function automatic logic [DW-1:0] data_of(input int o);
        case (o)
            0:       return bus.i_d_0;
            1:       return bus.i_d_1;
            2:       return bus.i_d_2;
            default: return bus.i_d_3;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        int n;
        if (rst) begin
            m_own  <= -1;
            m_hold <= 0;
            m_last <= 3;
        end else begin
            n = next_owner(m_own, m_hold, m_last, bus.i_req);
            if (n < 0)            m_hold <= 0;
            else if (n != m_own)  m_hold <= 1;
            else                  m_hold <= (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
            if (n >= 0) m_last <= n;
            m_own <= n;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_gnt", 32'(bus.o_gnt), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
            chk("model_valid", 32'(bus.o_valid), (m_own < 0) ? 32'd0 : 32'd1);
            if (m_own >= 0) chk("model_sel", 32'(bus.o_sel), 32'(m_own));
            chk("model_y", 32'(bus.o_y), (m_own < 0) ? 32'd0 : 32'(data_of(m_own)));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int exp_sel;
        bus.i_req = 4'b1111;
        bus.i_d_0 = 4'd0;
        bus.i_d_1 = 4'd1;
        bus.i_d_2 = 4'd2;
        bus.i_d_3 = 4'd3;

        // reset state, no clock edge yet
        #3;
        chk("rst_gnt", 32'(bus.o_gnt), 32'h0);
        chk("rst_sel", 32'(bus.o_sel), 32'h0);
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_y", 32'(bus.o_y), 32'h0);
        #5 rst = 1'b0;

        // rotation with all four requesting
        step(1);
        for (int i = 0; i < 16; i++) begin
`ifdef MUX41_ARB_FIXED_PRIO_EN
            exp_sel = (i / 4) % 2;
`else
            exp_sel = (i / 4) % 4;
`endif
            chk("rot_sel", 32'(bus.o_sel), 32'(exp_sel));
            chk("rot_y", 32'(bus.o_y), 32'(exp_sel));
            chk("rot_valid", 32'(bus.o_valid), 32'h1);
            step(1);
        end

        // single requester
        bus.i_req = 4'b0000;
        step(2);
        chk("idle_gnt", 32'(bus.o_gnt), 32'h0);
        bus.i_req = 4'b0100;
        bus.i_d_2 = 4'd6;
        step(1);
        chk("single_gnt", 32'(bus.o_gnt), 32'h4);
        chk("single_sel", 32'(bus.o_sel), 32'h2);
        chk("single_y", 32'(bus.o_y), 32'h6);
        bus.i_req = 4'b0000;
        step(1);
        chk("drop_gnt", 32'(bus.o_gnt), 32'h0);
        chk("drop_valid", 32'(bus.o_valid), 32'h0);
        chk("drop_y", 32'(bus.o_y), 32'h0);

        // sole requester keeps the grant, then saturated hold hands over
        bus.i_req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("sole_gnt", 32'(bus.o_gnt), 32'h1);
        end
        bus.i_req = 4'b0011;
        step(1);
        chk("sat_switch_gnt", 32'(bus.o_gnt), 32'h2);

        // handoff without bubble
        bus.i_req = 4'b0001;
        bus.i_d_3 = 4'd9;
        step(1);
        chk("ho_pre_gnt", 32'(bus.o_gnt), 32'h1);
        bus.i_req = 4'b1000;
        step(1);
        chk("ho_gnt", 32'(bus.o_gnt), 32'h8);
        chk("ho_valid", 32'(bus.o_valid), 32'h1);
        chk("ho_y", 32'(bus.o_y), 32'h9);

        // asynchronous reset in the middle of a grant
        bus.i_req = 4'b0100;
        step(1);
        chk("mid_gnt", 32'(bus.o_gnt), 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(bus.o_gnt), 32'h0);
        chk("arst_valid", 32'(bus.o_valid), 32'h0);
        chk("arst_y", 32'(bus.o_y), 32'h0);
        bus.i_req = 4'b1111;
        #2 rst = 1'b0;
        step(1);
        chk("post_rst_gnt", 32'(bus.o_gnt), 32'h1);
        step(3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
